maxpool1d: RTL and testbench
============================

// Module: maxpool1d
// PURPOSE
//   Non-overlapping 1-D max pooling (stride = POOL_SIZE) on a sequential fixed-point stream.
//   Sits directly downstream of the convolution/ReLU stage and consumes its valid/ready output.
//   Emits one beat per window: the maximum of that window. An optional last flag closes a
//   partial window at end of sequence.
// PARAMETERS
//   DATA_WIDTH  12  width of input/output samples (two's complement fixed point; fraction irrelevant)
//   POOL_SIZE   2   samples per window, and stride; legal range >= 2
//   SIGNED      1   1: signed comparison; 0: unsigned comparison
// PORTS
//   clk                   in   1           clock; all logic on rising edge
//   rst                   in   1           asynchronous, active-low reset
//   maxpool1d_ready_in    out  1           stage can accept an input beat this cycle
//   maxpool1d_valid_in    in   1           input beat valid
//   maxpool1d_data_in     in   DATA_WIDTH  input sample
//   maxpool1d_last_in     in   1           qualifies valid_in; beat is last of sequence
//   maxpool1d_ready_out   in   1           downstream accepts output beat
//   maxpool1d_valid_out   out  1           output beat valid (registered)
//   maxpool1d_data_out    out  DATA_WIDTH  window maximum (registered)
//   maxpool1d_last_out    out  1           output window closed by last_in (registered)
// BEHAVIOUR
//   - Reset: rst low asynchronously clears window count, running max, valid_out, data_out, last_out to 0.
//     This holds at any point, including mid-window and with valid_out held; partial window is discarded.
//   - Accept: in_fire = valid_in & ready_in. out_fire = valid_out & ready_out.
//   - Counter cnt, width clog2(POOL_SIZE), range 0..POOL_SIZE-1. It increments on in_fire and wraps to 0
//     when the window closes.
//   - Window closes on in_fire when cnt==POOL_SIZE-1 or last_in==1. On close, cnt returns to 0.
//   - Running max: on in_fire with cnt==0, max_r <= data_in. Otherwise max_r <= (data_in > max_r) ? data_in : max_r.
//     Ties keep the earlier value (no observable difference). SIGNED selects $signed vs unsigned comparison.
//   - On close: data_out <= max(max_r, data_in) (data_in alone if cnt==0), last_out <= last_in, valid_out <= 1.
//     Latency is one cycle from the closing in_fire to valid_out.
//   - ready_in = ~valid_out | ready_out | ~closing, where closing = (cnt==POOL_SIZE-1) | last_in.
//     Non-closing beats are always accepted. A closing beat stalls only while the output register is full
//     and not draining.
//   - valid_out clears on out_fire unless a new window closes in the same cycle; in that case it stays 1 and
//     data/last update. data_out and last_out stay stable while valid_out & ~ready_out.
//   - Throughput: one input beat per cycle sustained; one output per POOL_SIZE inputs.
//   - last_in with cnt==0 yields a single-sample window (output = that sample).
//   - valid_in low: no state change. Inputs are ignored when ready_in is low.
// TESTING
//   1 POOL_SIZE=2, ready_out=1, in 3,7,5,1 -> out 7 then 5, each 1 cycle after 2nd/4th beat; last_out=0.
//   2 SIGNED=1, in 0xFFC(-4),0xFFE(-2) -> out 0xFFE; with SIGNED=0 the same input -> 0xFFE. Then in 0x001,0x800
//     gives 0x001 signed and 0x800 unsigned.
//   3 Backpressure: POOL_SIZE=2, ready_out=0, stream 1,2,3,4 -> out 2 held stable, ready_in low on beat 4.
//     Release ready_out -> 2 then 4 in order; none lost or duplicated.
//   4 Partial window: POOL_SIZE=3, in 5, then 8 with last_in=1 -> out 8, last_out=1. Next window starts at
//     cnt=0 (in 1,2,0 -> out 2).
//   5 Reset mid-window: POOL_SIZE=4, in 9,9, assert rst low -> valid_out=0 immediately. After release,
//     in 1,2,3,4 -> out 4 (no 9).
//   6 Simultaneous: valid_out=1 with ready_out=1 while the closing beat arrives -> valid_out stays 1 and
//     data_out is the new max the next cycle.

Source files
------------

// File: rtl/maxpool1d.sv
// rtl/maxpool1d.sv - non-overlapping 1-D max pooling over a valid/ready sample stream
module maxpool1d #(
    parameter int DATA_WIDTH = 12,
    parameter int POOL_SIZE  = 2,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  maxpool1d_ready_in,
    input  logic                  maxpool1d_valid_in,
    input  logic [DATA_WIDTH-1:0] maxpool1d_data_in,
    input  logic                  maxpool1d_last_in,
    input  logic                  maxpool1d_ready_out,
    output logic                  maxpool1d_valid_out,
    output logic [DATA_WIDTH-1:0] maxpool1d_data_out,
    output logic                  maxpool1d_last_out
);
    localparam int CW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(POOL_SIZE - 1);

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] max_r;
    logic                  closing;
    logic                  in_fire;
    logic                  out_fire;
    logic                  gt;
    logic [DATA_WIDTH-1:0] cand;

    assign closing  = (cnt == CNT_MAX) | maxpool1d_last_in;
    assign maxpool1d_ready_in = ~maxpool1d_valid_out | maxpool1d_ready_out | ~closing;
    assign in_fire  = maxpool1d_valid_in & maxpool1d_ready_in;
    assign out_fire = maxpool1d_valid_out & maxpool1d_ready_out;

    assign gt   = (SIGNED != 0) ? ($signed(maxpool1d_data_in) > $signed(max_r))
                                : (maxpool1d_data_in > max_r);
    // First sample of a window seeds the max regardless of the stale register
    assign cand = ((cnt == '0) || gt) ? maxpool1d_data_in : max_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt                 <= '0;
            max_r               <= '0;
            maxpool1d_valid_out <= 1'b0;
            maxpool1d_data_out  <= '0;
            maxpool1d_last_out  <= 1'b0;
        end else begin
            if (in_fire) begin
                max_r <= cand;
                cnt   <= closing ? '0 : cnt + CW'(1);
            end
            if (in_fire && closing) begin
                maxpool1d_valid_out <= 1'b1;
                maxpool1d_data_out  <= cand;
                maxpool1d_last_out  <= maxpool1d_last_in;
            end else if (out_fire) begin
                maxpool1d_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_maxpool1d.sv
// tb/tb_maxpool1d.sv - directed self-checking bench for maxpool1d
module tb_maxpool1d;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  vin  = '0;
    logic [3:0]  lin  = '0;
    logic [3:0]  rout = '0;
    logic [3:0]  rin;
    logic [3:0]  vout;
    logic [3:0]  lout;
    logic [11:0] din [4];
    logic [11:0] dout [4];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    // inst 0: P=2 signed, 1: P=2 unsigned, 2: P=3 signed, 3: P=4 signed
    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(2), .SIGNED(1)) u0 (
        .clk(clk), .rst(rst), .maxpool1d_ready_in(rin[0]), .maxpool1d_valid_in(vin[0]),
        .maxpool1d_data_in(din[0]), .maxpool1d_last_in(lin[0]), .maxpool1d_ready_out(rout[0]),
        .maxpool1d_valid_out(vout[0]), .maxpool1d_data_out(dout[0]), .maxpool1d_last_out(lout[0]));
    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(2), .SIGNED(0)) u1 (
        .clk(clk), .rst(rst), .maxpool1d_ready_in(rin[1]), .maxpool1d_valid_in(vin[1]),
        .maxpool1d_data_in(din[1]), .maxpool1d_last_in(lin[1]), .maxpool1d_ready_out(rout[1]),
        .maxpool1d_valid_out(vout[1]), .maxpool1d_data_out(dout[1]), .maxpool1d_last_out(lout[1]));
    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(3), .SIGNED(1)) u2 (
        .clk(clk), .rst(rst), .maxpool1d_ready_in(rin[2]), .maxpool1d_valid_in(vin[2]),
        .maxpool1d_data_in(din[2]), .maxpool1d_last_in(lin[2]), .maxpool1d_ready_out(rout[2]),
        .maxpool1d_valid_out(vout[2]), .maxpool1d_data_out(dout[2]), .maxpool1d_last_out(lout[2]));
    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(4), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst), .maxpool1d_ready_in(rin[3]), .maxpool1d_valid_in(vin[3]),
        .maxpool1d_data_in(din[3]), .maxpool1d_last_in(lin[3]), .maxpool1d_ready_out(rout[3]),
        .maxpool1d_valid_out(vout[3]), .maxpool1d_data_out(dout[3]), .maxpool1d_last_out(lout[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Presents one beat, waits (bounded) for ready_in, returns #1 after the accepting edge
    task automatic send(input int k, input logic [11:0] d, input logic l);
        int n;
        n = 0;
        din[k] = d;
        lin[k] = l;
        vin[k] = 1'b1;
        while (!rin[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        vin[k] = 1'b0;
        lin[k] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(vout), 32'd0);
        chk("reset_data3", 32'(dout[3]), 32'd0);
        chk("reset_last",  32'(lout), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // basic pooling, window of 2
        rout = 4'b1111;
        send(0, 12'd3, 1'b0);
        chk("t1_no_early_valid", 32'(vout[0]), 32'd0);
        send(0, 12'd7, 1'b0);
        chk("t1_valid_a", 32'(vout[0]), 32'd1);
        chk("t1_data_a",  32'(dout[0]), 32'd7);
        chk("t1_last_a",  32'(lout[0]), 32'd0);
        send(0, 12'd5, 1'b0);
        chk("t1_drained", 32'(vout[0]), 32'd0);
        send(0, 12'd1, 1'b0);
        chk("t1_valid_b", 32'(vout[0]), 32'd1);
        chk("t1_data_b",  32'(dout[0]), 32'd5);

        // signed vs unsigned comparison
        send(0, 12'hFFC, 1'b0);
        send(0, 12'hFFE, 1'b0);
        chk("t2_signed_neg", 32'(dout[0]), 32'hFFE);
        send(1, 12'hFFC, 1'b0);
        send(1, 12'hFFE, 1'b0);
        chk("t2_unsigned_neg", 32'(dout[1]), 32'hFFE);
        send(0, 12'h001, 1'b0);
        send(0, 12'h800, 1'b0);
        chk("t2_signed_mix", 32'(dout[0]), 32'h001);
        send(1, 12'h001, 1'b0);
        send(1, 12'h800, 1'b0);
        chk("t2_unsigned_mix", 32'(dout[1]), 32'h800);

        // single-sample window closed by last
        send(0, 12'd6, 1'b1);
        chk("t_single_data", 32'(dout[0]), 32'd6);
        chk("t_single_last", 32'(lout[0]), 32'd1);

        // backpressure, then simultaneous drain and close
        @(negedge clk);
        rout[1] = 1'b0;
        @(negedge clk);
        chk("t3_idle", 32'(vout[1]), 32'd0);
        send(1, 12'd1, 1'b0);
        send(1, 12'd2, 1'b0);
        send(1, 12'd3, 1'b0);
        din[1] = 12'd4;
        vin[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", 32'(rin[1]), 32'd0);
            chk("t3_hold_valid", 32'(vout[1]), 32'd1);
            chk("t3_hold_data", 32'(dout[1]), 32'd2);
        end
        rout[1] = 1'b1;
        #1;
        chk("t3_ready_release", 32'(rin[1]), 32'd1);
        @(posedge clk);
        #1;
        vin[1] = 1'b0;
        chk("t6_valid_kept", 32'(vout[1]), 32'd1);
        chk("t6_new_data", 32'(dout[1]), 32'd4);
        @(posedge clk);
        #1;
        chk("t3_final_drain", 32'(vout[1]), 32'd0);

        // partial window closed by last, then a fresh full window
        send(2, 12'd5, 1'b0);
        send(2, 12'd8, 1'b1);
        chk("t4_valid", 32'(vout[2]), 32'd1);
        chk("t4_data",  32'(dout[2]), 32'd8);
        chk("t4_last",  32'(lout[2]), 32'd1);
        send(2, 12'd1, 1'b0);
        send(2, 12'd2, 1'b0);
        chk("t4_no_early", 32'(vout[2]), 32'd0);
        send(2, 12'd0, 1'b0);
        chk("t4_data2", 32'(dout[2]), 32'd2);
        chk("t4_last2", 32'(lout[2]), 32'd0);

        // reset with an output held and a window half filled
        rout[3] = 1'b0;
        for (int i = 0; i < 6; i++) send(3, 12'd9, 1'b0);
        chk("t5_held", 32'(vout[3]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_valid", 32'(vout[3]), 32'd0);
        chk("t5_async_data",  32'(dout[3]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rout[3] = 1'b1;
        send(3, 12'd1, 1'b0);
        send(3, 12'd2, 1'b0);
        send(3, 12'd3, 1'b0);
        chk("t5_no_stale_close", 32'(vout[3]), 32'd0);
        send(3, 12'd4, 1'b0);
        chk("t5_valid", 32'(vout[3]), 32'd1);
        chk("t5_data",  32'(dout[3]), 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
